ac97_frame_rx: RTL and testbench

//  Codec-end receiver for the AC97 serial link: samples the Sync/SData_Out stream produced by the
//  AC97 controller and recovers the tag, command (slots 1/2) and PCM playback (slots 3/4) fields.

---
 rtl/ac97_frame_rx_pkg.sv | 45 ++++
 rtl/ac97_frame_rx_if.sv | 31 +++
 rtl/ac97_frame_rx_slot_shifter.sv | 37 +++
 rtl/ac97_frame_rx.sv | 176 +++++++++++++++++
 tb/tb_ac97_frame_rx.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ac97_frame_rx_pkg.sv
// Shared AC97 frame constants, slot geometry, tag bit positions and types.
package ac97_frame_rx_pkg;

    localparam int unsigned FRAME_BITS   = 256;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned TAG_W        = 16;
    localparam int unsigned SLOT_W       = 20;
    localparam int unsigned SYNC_LEN     = 16;
    localparam int unsigned SAMPLE_WIDTH = 16;
    localparam int unsigned CMD_ADDR_W   = 7;
    localparam int unsigned CMD_DATA_W   = 16;

    // Tag bit positions: frame valid, then per-slot valid flags.
    localparam int unsigned TAG_FRAME_VALID = 15;
    localparam int unsigned TAG_SLOT1       = 14;
    localparam int unsigned TAG_SLOT2       = 13;
    localparam int unsigned TAG_SLOT3       = 12;
    localparam int unsigned TAG_SLOT4       = 11;

    // Slot 1 read/not-write flag.
    localparam int unsigned SLOT1_RW_BIT = 19;

    // Bit index of the last bit of a slot (slot 0 is the tag).
    function automatic logic [CNT_W-1:0] slot_last_bit(input int unsigned slot);
        return CNT_W'(TAG_W - 1 + SLOT_W * slot);
    endfunction

    localparam logic [CNT_W-1:0] TAG_LAST   = slot_last_bit(0);
    localparam logic [CNT_W-1:0] SLOT1_LAST = slot_last_bit(1);
    localparam logic [CNT_W-1:0] SLOT2_LAST = slot_last_bit(2);
    localparam logic [CNT_W-1:0] SLOT3_LAST = slot_last_bit(3);
    localparam logic [CNT_W-1:0] SLOT4_LAST = slot_last_bit(4);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    // Slot 1 command header: R/W flag followed by register address.
    typedef struct packed {
        logic                  rw;
        logic [CMD_ADDR_W-1:0] addr;
    } cmd_hdr_t;

endpackage

// File: rtl/ac97_frame_rx_if.sv
// AC97 serial link inputs plus the decoded receiver outputs.
interface ac97_frame_rx_if;
    import ac97_frame_rx_pkg::*;

    logic                    bit_en;
    logic                    sync;
    logic                    sdata;
    logic                    locked;
    logic [SAMPLE_WIDTH-1:0] pcm_left;
    logic [SAMPLE_WIDTH-1:0] pcm_right;
    logic                    pcm_valid;
    logic [CMD_ADDR_W-1:0]   cmd_addr;
    logic [CMD_DATA_W-1:0]   cmd_data;
    logic                    cmd_write;
    logic                    sync_err;

    // Link driver side (controller or bench).
    modport master (
        output bit_en, sync, sdata,
        input  locked, pcm_left, pcm_right, pcm_valid,
        input  cmd_addr, cmd_data, cmd_write, sync_err
    );

    // Receiver side.
    modport slave (
        input  bit_en, sync, sdata,
        output locked, pcm_left, pcm_right, pcm_valid,
        output cmd_addr, cmd_data, cmd_write, sync_err
    );

endinterface

// File: rtl/ac97_frame_rx_slot_shifter.sv
// 20-bit MSB-first shift register; word_c includes the bit being strobed now,
// so the full slot is visible in the same cycle as its last bit.
module ac97_frame_rx_slot_shifter
    import ac97_frame_rx_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              shift_en,
    input  logic              din,
    input  logic              last,
    output logic [SLOT_W-1:0] word_c,
    output logic              done_c
);

    logic [SLOT_W-2:0] shreg_q, shreg_d;

    // Shift one bit in per strobe.
    always_comb begin
        shreg_d = shreg_q;
        if (shift_en) begin
            shreg_d = {shreg_q[SLOT_W-3:0], din};
        end
    end

    // Shift register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign word_c = {shreg_q, din};
    assign done_c = shift_en & last;

endmodule

// File: rtl/ac97_frame_rx.sv
// AC97 codec-end frame receiver: Sync alignment, tag latch, command and PCM recovery.
module ac97_frame_rx
    import ac97_frame_rx_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    ac97_frame_rx_if.slave  bus
);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sync_prev_q, sync_prev_d;
    logic                    locked_q, locked_d;
    logic                    sync_err_q, sync_err_d;

    logic [TAG_W-1:0]        tag_q, tag_d;
    cmd_hdr_t                hdr_q, hdr_d;
    logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
    logic [SAMPLE_WIDTH-1:0] pcm_left_q, pcm_left_d;
    logic [SAMPLE_WIDTH-1:0] pcm_right_q, pcm_right_d;
    logic                    pcm_valid_q, pcm_valid_d;
    logic [CMD_ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [CMD_DATA_W-1:0]   cmd_data_q, cmd_data_d;
    logic                    cmd_write_q, cmd_write_d;

    logic                    rise_c;
    logic                    lock_err_c;
    logic [CNT_W-1:0]        idx_c;
    logic                    slot_last_c;
    logic                    slot_done_c;
    logic                    take_c;
    logic [SLOT_W-1:0]       slot_word_c;

    // Sync rising edge, bit index of the current strobe, and framing checks.
    assign rise_c     = bus.bit_en & bus.sync & ~sync_prev_q;
    assign idx_c      = (state_q == ST_LOCK) ? cnt_q : '0;
    assign lock_err_c = bus.bit_en && (state_q == ST_LOCK) &&
                        ((rise_c && (cnt_q != '0)) ||
                         ((cnt_q < CNT_W'(SYNC_LEN)) ? !bus.sync : bus.sync));

    assign slot_last_c = (idx_c == TAG_LAST)   || (idx_c == SLOT1_LAST) ||
                         (idx_c == SLOT2_LAST) || (idx_c == SLOT3_LAST) ||
                         (idx_c == SLOT4_LAST);

    ac97_frame_rx_slot_shifter u_shifter (
        .clk      (clk),
        .reset_n  (reset_n),
        .shift_en (bus.bit_en),
        .din      (bus.sdata),
        .last     (slot_last_c),
        .word_c   (slot_word_c),
        .done_c   (slot_done_c)
    );

    // A slot boundary only counts inside a correctly framed, locked frame.
    assign take_c = slot_done_c && (state_q == ST_LOCK) && !lock_err_c;

    // FSM next state: alignment hunt, bit counting and framing errors.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sync_prev_d = sync_prev_q;
        sync_err_d  = 1'b0;
        if (bus.bit_en) begin
            sync_prev_d = bus.sync;
            if (state_q == ST_HUNT) begin
                if (rise_c) begin
                    state_d = ST_LOCK;
                    cnt_d   = CNT_W'(1);
                end
            end else if (lock_err_c) begin
                sync_err_d = 1'b1;
                // A misplaced rising edge is taken as bit 0 of a new frame.
                if (rise_c) begin
                    state_d = ST_LOCK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ST_HUNT;
                    cnt_d   = '0;
                end
            end else begin
                cnt_d = (cnt_q == CNT_W'(FRAME_BITS - 1)) ? '0 : cnt_q + CNT_W'(1);
            end
        end
        // Locked drops for the error cycle even on an immediate relock.
        locked_d = (state_d == ST_LOCK) && !sync_err_d;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HUNT;
            cnt_q       <= '0;
            sync_prev_q <= 1'b0;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_prev_q <= sync_prev_d;
            locked_q    <= locked_d;
            sync_err_q  <= sync_err_d;
        end
    end

    // Field capture at slot boundaries and output pulse generation.
    always_comb begin
        tag_d       = tag_q;
        hdr_d       = hdr_q;
        left_hold_d = left_hold_q;
        pcm_left_d  = pcm_left_q;
        pcm_right_d = pcm_right_q;
        pcm_valid_d = 1'b0;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_write_d = 1'b0;
        if (take_c) begin
            if (idx_c == TAG_LAST) begin
                tag_d = slot_word_c[TAG_W-1:0];
            end
            if (idx_c == SLOT1_LAST) begin
                hdr_d = cmd_hdr_t'(slot_word_c[SLOT1_RW_BIT -: $bits(cmd_hdr_t)]);
            end
            if ((idx_c == SLOT2_LAST) && tag_q[TAG_FRAME_VALID] && tag_q[TAG_SLOT1] &&
                tag_q[TAG_SLOT2] && !hdr_q.rw) begin
                cmd_write_d = 1'b1;
                cmd_addr_d  = hdr_q.addr;
                cmd_data_d  = slot_word_c[SLOT_W-1 -: CMD_DATA_W];
            end
            if (idx_c == SLOT3_LAST) begin
                left_hold_d = slot_word_c[SLOT_W-1 -: SAMPLE_WIDTH];
            end
            if ((idx_c == SLOT4_LAST) && tag_q[TAG_FRAME_VALID] && tag_q[TAG_SLOT3] &&
                tag_q[TAG_SLOT4]) begin
                pcm_valid_d = 1'b1;
                pcm_left_d  = left_hold_q;
                pcm_right_d = slot_word_c[SLOT_W-1 -: SAMPLE_WIDTH];
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q       <= '0;
            hdr_q       <= '0;
            left_hold_q <= '0;
            pcm_left_q  <= '0;
            pcm_right_q <= '0;
            pcm_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_write_q <= 1'b0;
        end else begin
            tag_q       <= tag_d;
            hdr_q       <= hdr_d;
            left_hold_q <= left_hold_d;
            pcm_left_q  <= pcm_left_d;
            pcm_right_q <= pcm_right_d;
            pcm_valid_q <= pcm_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_write_q <= cmd_write_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.sync_err  = sync_err_q;
    assign bus.pcm_left  = pcm_left_q;
    assign bus.pcm_right = pcm_right_q;
    assign bus.pcm_valid = pcm_valid_q;
    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.cmd_write = cmd_write_q;

endmodule

// File: tb/tb_ac97_frame_rx.sv
// Directed bench for ac97_frame_rx with a pulse scoreboard.
module tb_ac97_frame_rx;

    logic clk;
    logic reset_n;

    ac97_frame_rx_if bus ();

    ac97_frame_rx dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cur_bit  = 0;
    logic        strobe_seen = 1'b0;

    logic [31:0] exp_pcm[$];   // {left, right}
    logic [22:0] exp_cmd[$];   // {addr, data}
    int          exp_err[$];   // frame bit index of the offending strobe

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected pulses for a frame that is received without framing errors.
    task automatic expect_frame(input logic [15:0] tag, input logic [19:0] s1,
                                input logic [19:0] s2, input logic [19:0] s3,
                                input logic [19:0] s4);
        if (tag[15] && tag[12] && tag[11]) exp_pcm.push_back({s3[19:4], s4[19:4]});
        if (tag[15] && tag[14] && tag[13] && !s1[19]) exp_cmd.push_back({s1[18:12], s2[19:4]});
    endtask

    function automatic logic [255:0] build_sd(input logic [15:0] tag, input logic [19:0] s1,
                                              input logic [19:0] s2, input logic [19:0] s3,
                                              input logic [19:0] s4);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i] = tag[15-i];
        for (int j = 0; j < 20; j++) begin
            v[16+j] = s1[19-j];
            v[36+j] = s2[19-j];
            v[56+j] = s3[19-j];
            v[76+j] = s4[19-j];
        end
        for (int i = 96; i < 256; i++) v[i] = 1'($urandom);
        return v;
    endfunction

    function automatic logic [255:0] build_sy(input int hold);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < hold; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Called #1 after every clock edge: consumes pulses against the scoreboard.
    task automatic observe();
        logic [31:0] e;
        logic [22:0] c;
        int          b;
        if (bus.pcm_valid) begin
            if (exp_pcm.size() == 0) begin
                chk("pcm_valid_unexpected", 64'(bus.pcm_valid), 64'(0));
            end else begin
                e = exp_pcm.pop_front();
                chk("pcm_valid_timing", 64'({strobe_seen, 8'(cur_bit)}), 64'({1'b1, 8'd95}));
                chk("pcm_left", 64'(bus.pcm_left), 64'(e[31:16]));
                chk("pcm_right", 64'(bus.pcm_right), 64'(e[15:0]));
            end
        end
        if (bus.cmd_write) begin
            if (exp_cmd.size() == 0) begin
                chk("cmd_write_unexpected", 64'(bus.cmd_write), 64'(0));
            end else begin
                c = exp_cmd.pop_front();
                chk("cmd_write_timing", 64'({strobe_seen, 8'(cur_bit)}), 64'({1'b1, 8'd55}));
                chk("cmd_addr", 64'(bus.cmd_addr), 64'(c[22:16]));
                chk("cmd_data", 64'(bus.cmd_data), 64'(c[15:0]));
            end
        end
        if (bus.sync_err) begin
            if (exp_err.size() == 0) begin
                chk("sync_err_unexpected", 64'(bus.sync_err), 64'(0));
            end else begin
                b = exp_err.pop_front();
                chk("sync_err_timing", 64'({strobe_seen, 8'(cur_bit)}), 64'({1'b1, 8'(b)}));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            bus.bit_en  = 1'b0;
            strobe_seen = 1'b0;
            @(posedge clk);
            #1;
            observe();
        end
    endtask

    // Sends frame bits first..last; gap idle cycles with junk on the link follow each strobe.
    task automatic send_bits(input logic [255:0] sd, input logic [255:0] sy,
                             input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            bus.bit_en  = 1'b1;
            bus.sync    = sy[i];
            bus.sdata   = sd[i];
            cur_bit     = i;
            strobe_seen = 1'b1;
            @(posedge clk);
            #1;
            observe();
            for (int g = 0; g < gap; g++) begin
                bus.bit_en  = 1'b0;
                bus.sync    = 1'($urandom);
                bus.sdata   = 1'($urandom);
                strobe_seen = 1'b0;
                @(posedge clk);
                #1;
                observe();
            end
        end
        bus.bit_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({bus.locked, bus.pcm_left, bus.pcm_right, bus.pcm_valid,
                      bus.cmd_addr, bus.cmd_data, bus.cmd_write, bus.sync_err}), 64'(0));
    endtask

    task automatic chk_drained(input string tag);
        chk(tag, 64'({8'(exp_pcm.size()), 8'(exp_cmd.size()), 8'(exp_err.size())}), 64'(0));
    endtask

    initial begin
        logic [255:0] sd;
        logic [255:0] sy;
        logic [15:0]  l;
        logic [19:0]  s1;
        logic [19:0]  s2;
        logic [19:0]  s3;
        logic [19:0]  s4;

        // Reset held with junk on the link.
        reset_n    = 1'b0;
        bus.bit_en = 1'b0;
        bus.sync   = 1'b0;
        bus.sdata  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            bus.bit_en = 1'($urandom);
            bus.sync   = 1'($urandom);
            bus.sdata  = 1'($urandom);
            @(posedge clk);
            #1;
            chk_all_zero("reset_outputs");
        end
        bus.bit_en = 1'b0;
        bus.sync   = 1'b0;
        reset_n    = 1'b1;
        idle(2);
        chk("locked_before_frame", 64'(bus.locked), 64'(0));

        // First legal frame.
        s3 = {16'h1234, 4'h5};
        s4 = {16'hABCD, 4'hA};
        sd = build_sd(16'h9800, 20'hFFFFF, 20'h12345, s3, s4);
        sy = build_sy(16);
        expect_frame(16'h9800, 20'hFFFFF, 20'h12345, s3, s4);
        send_bits(sd, sy, 0, 0, 0);
        chk("locked_after_bit0", 64'(bus.locked), 64'(1));
        send_bits(sd, sy, 1, 255, 0);
        chk_drained("frame1_drained");
        chk("pcm_left_hold", 64'(bus.pcm_left), 64'(16'h1234));

        // Ramp: three frames at full rate, then three at one strobe in four clocks.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                l  = 16'h1000 + 16'(k) * 16'h0111 + 16'(r) * 16'h2000;
                s3 = {l, 4'($urandom)};
                s4 = {~l, 4'($urandom)};
                sd = build_sd(16'h9800, 20'($urandom), 20'($urandom), s3, s4);
                expect_frame(16'h9800, 20'h0, 20'h0, s3, s4);
                send_bits(sd, sy, 0, 255, r * 3);
            end
        end
        chk_drained("ramp_drained");

        // Register write, then a read that must leave the command outputs alone.
        s1 = {1'b0, 7'h02, 12'h000};
        s2 = {16'h0808, 4'h0};
        sd = build_sd(16'hE000, s1, s2, 20'h11111, 20'h22222);
        expect_frame(16'hE000, s1, s2, 20'h11111, 20'h22222);
        send_bits(sd, sy, 0, 255, 0);
        s1 = {1'b1, 7'h55, 12'hFFF};
        s2 = {16'hBEEF, 4'hF};
        sd = build_sd(16'hE000, s1, s2, 20'h11111, 20'h22222);
        expect_frame(16'hE000, s1, s2, 20'h11111, 20'h22222);
        send_bits(sd, sy, 0, 255, 0);
        chk_drained("cmd_drained");
        chk("cmd_after_read", 64'({bus.cmd_addr, bus.cmd_data}), 64'({7'h02, 16'h0808}));

        // Sync re-asserted at bit 100: error, one cycle unlocked, relock on that edge.
        s3 = {16'h5A5A, 4'h0};
        s4 = {16'hC3C3, 4'h0};
        sd = build_sd(16'h9800, 20'h0, 20'h0, s3, s4);
        expect_frame(16'h9800, 20'h0, 20'h0, s3, s4);
        send_bits(sd, sy, 0, 99, 0);
        s3 = {16'h0F0F, 4'h3};
        s4 = {16'hF0F0, 4'hC};
        sd = build_sd(16'hF800, {1'b0, 7'h33, 12'h0}, {16'h4444, 4'h0}, s3, s4);
        expect_frame(16'hF800, {1'b0, 7'h33, 12'h0}, {16'h4444, 4'h0}, s3, s4);
        exp_err.push_back(0);
        send_bits(sd, sy, 0, 0, 0);
        chk("locked_during_err", 64'(bus.locked), 64'(0));
        send_bits(sd, sy, 1, 1, 0);
        chk("locked_relock", 64'(bus.locked), 64'(1));
        send_bits(sd, sy, 2, 255, 0);
        chk_drained("resync_drained");

        // Sync too short: error at bit 15, unlocked for the rest of the frame.
        sd = build_sd(16'hF800, 20'h0, 20'h0, 20'h12345, 20'h54321);
        exp_err.push_back(15);
        send_bits(sd, build_sy(15), 0, 255, 0);
        chk("locked_after_short_sync", 64'(bus.locked), 64'(0));

        // Relock on the next good frame.
        s1 = {1'b0, 7'h11, 12'h0};
        s2 = {16'h2222, 4'h0};
        sd = build_sd(16'hE000, s1, s2, 20'h0, 20'h0);
        expect_frame(16'hE000, s1, s2, 20'h0, 20'h0);
        send_bits(sd, sy, 0, 255, 0);

        // Sync too long: error at bit 16, no pulses even though the tag was valid.
        sd = build_sd(16'hF800, 20'h0, 20'h0, 20'h77777, 20'h88888);
        exp_err.push_back(16);
        send_bits(sd, build_sy(17), 0, 255, 0);
        chk("locked_after_long_sync", 64'(bus.locked), 64'(0));

        // Tag 0: no pulses and outputs unchanged.
        sd = build_sd(16'h0000, 20'h0, 20'h0, 20'h99999, 20'h66666);
        send_bits(sd, sy, 0, 255, 1);
        chk_drained("tag0_drained");
        chk("tag0_hold", 64'({bus.pcm_left, bus.cmd_addr, bus.cmd_data}),
            64'({16'h0F0F, 7'h11, 16'h2222}));

        // Reset mid-frame discards the partial frame; next frame decodes.
        sd = build_sd(16'hF800, {1'b0, 7'h7F, 12'h0}, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);
        send_bits(sd, sy, 0, 40, 0);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset_outputs");
        idle(2);
        reset_n = 1'b1;
        idle(1);
        s3 = {16'h2468, 4'h0};
        s4 = {16'h1357, 4'h0};
        sd = build_sd(16'h9800, 20'h0, 20'h0, s3, s4);
        expect_frame(16'h9800, 20'h0, 20'h0, s3, s4);
        send_bits(sd, sy, 0, 255, 0);
        idle(3);
        chk_drained("final_drained");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
